// File: rtl/apb_slave_array_if.sv
// APB4 bus bundle between the bridge (master) and the bank of completer models (slave).
interface apb_slave_array_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NO_OF_SLAVES  = 8
);
  logic [NO_OF_SLAVES-1:0]            PSELx;
  logic [ADDRESS_WIDTH-1:0]           PADDR;
  logic                               PWRITE;
  logic                               PENABLE;
  logic [DATA_WIDTH-1:0]              PWDATA;
  logic [DATA_WIDTH/8-1:0]            PSTRB;
  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] PRDATA;
  logic [NO_OF_SLAVES-1:0]            PREADY;
  logic [NO_OF_SLAVES-1:0]            PSLVERR;

  modport master (
    output PSELx, PADDR, PWRITE, PENABLE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PADDR, PWRITE, PENABLE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_array.sv
// Bank of NO_OF_SLAVES independent APB4 completers with register files, byte strobes and error decode.
// Define APB_WAIT_STATE_EN to enable per-slave programmable wait states from wait_cfg.
module apb_slave_array #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NO_OF_SLAVES   = 8,
  parameter int REGS_PER_SLAVE = 16,
  parameter int WAIT_WIDTH     = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NO_OF_SLAVES*WAIT_WIDTH-1:0] wait_cfg,
  apb_slave_array_if.slave                   bus,
  output logic [NO_OF_SLAVES-1:0]            state_dbg
);
  localparam int IW = $clog2(REGS_PER_SLAVE);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  // Address decode is shared; each slave latches it at its own SETUP edge.
  logic [IW-1:0] dec_index;
  logic          dec_err;
  assign dec_index = bus.PADDR[2 +: IW];
  assign dec_err   = (bus.PADDR[1:0] != 2'b00) || ((bus.PADDR >> (2 + IW)) != '0);

`ifndef APB_WAIT_STATE_EN
  logic unused_wait_cfg;
  assign unused_wait_cfg = ^wait_cfg;
`endif

  for (genvar g = 0; g < NO_OF_SLAVES; g++) begin : g_slave
    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  wr_q, wr_d;
    logic                  ready_q, ready_d;
    logic                  slverr_q, slverr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] regs [REGS_PER_SLAVE];
    logic                  do_write;
    logic                  sel;
`ifdef APB_WAIT_STATE_EN
    logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
`endif

    assign sel = bus.PSELx[g];

    always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      err_d    = err_q;
      wr_d     = wr_q;
      ready_d  = ready_q;
      slverr_d = slverr_q;
      rdata_d  = rdata_q;
      do_write = 1'b0;
`ifdef APB_WAIT_STATE_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
        IDLE: begin
          if (sel && !bus.PENABLE) begin
            state_d = ACCESS;
            idx_d   = dec_index;
            err_d   = dec_err;
            wr_d    = bus.PWRITE;
`ifdef APB_WAIT_STATE_EN
            cnt_d   = wait_cfg[g*WAIT_WIDTH +: WAIT_WIDTH];
            if (cnt_d == '0) begin
              ready_d  = 1'b1;
              slverr_d = dec_err;
              rdata_d  = (dec_err || bus.PWRITE) ? '0 : regs[dec_index];
            end
`else
            ready_d  = 1'b1;
            slverr_d = dec_err;
            rdata_d  = (dec_err || bus.PWRITE) ? '0 : regs[dec_index];
`endif
          end
        end
        ACCESS: begin
          if (!sel) begin
            // Abort: master withdrew the select, nothing is committed.
            state_d  = IDLE;
            ready_d  = 1'b0;
            slverr_d = 1'b0;
            rdata_d  = '0;
`ifdef APB_WAIT_STATE_EN
            cnt_d    = '0;
`endif
          end else if (bus.PENABLE && ready_q) begin
            state_d  = IDLE;
            do_write = wr_q && !err_q;
            ready_d  = 1'b0;
            slverr_d = 1'b0;
            rdata_d  = '0;
          end
`ifdef APB_WAIT_STATE_EN
          else if (cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_WIDTH'(1);
            if (cnt_q == WAIT_WIDTH'(1)) begin
              ready_d  = 1'b1;
              slverr_d = err_q;
              rdata_d  = (err_q || wr_q) ? '0 : regs[idx_q];
            end
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q  <= IDLE;
        idx_q    <= '0;
        err_q    <= 1'b0;
        wr_q     <= 1'b0;
        ready_q  <= 1'b0;
        slverr_q <= 1'b0;
        rdata_q  <= '0;
`ifdef APB_WAIT_STATE_EN
        cnt_q    <= '0;
`endif
      end else begin
        state_q  <= state_d;
        idx_q    <= idx_d;
        err_q    <= err_d;
        wr_q     <= wr_d;
        ready_q  <= ready_d;
        slverr_q <= slverr_d;
        rdata_q  <= rdata_d;
`ifdef APB_WAIT_STATE_EN
        cnt_q    <= cnt_d;
`endif
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int r = 0; r < REGS_PER_SLAVE; r++) regs[r] <= '0;
      end else if (do_write) begin
        for (int k = 0; k < SW; k++)
          if (bus.PSTRB[k]) regs[idx_q][k*8 +: 8] <= bus.PWDATA[k*8 +: 8];
      end
    end

    assign bus.PREADY[g]                          = ready_q;
    assign bus.PSLVERR[g]                         = slverr_q;
    assign bus.PRDATA[g*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
    assign state_dbg[g]                           = (state_q == ACCESS);
  end
endmodule

// File: tb/tb_apb_slave_array.sv
// Self-checking bench for apb_slave_array: vector table, random traffic against a register model, abort and reset sequences.
module tb_apb_slave_array;
  logic        clock;
  logic        reset;
  logic [31:0] wait_cfg;
  logic [7:0]  state_dbg;

  apb_slave_array_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NO_OF_SLAVES(8)) bus ();

  apb_slave_array dut (
    .clock     (clock),
    .reset     (reset),
    .wait_cfg  (wait_cfg),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          s;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wt;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  vec_t        tbl [20];
  logic [31:0] model [8][16];
  logic [32:0] exp_q [$];
  int          wait_q [$];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic int eff_wait(input int wt);
`ifdef APB_WAIT_STATE_EN
    return wt;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 8; s++)
      for (int r = 0; r < 16; r++) model[s][r] = '0;
  endtask

  // driver: called at a drive point (#1 after a rising edge); leaves the bus idle at the next one
  task automatic drive_xfer(input int s, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb, input int wt);
    logic [32:0] exp;
    int          exp_wt;
    int          cyc;
    bit          done;
    logic [31:0] wt_v;
    wt_v          = wt;
    bus.PSELx     = '0;
    bus.PSELx[s]  = 1'b1;
    bus.PADDR     = addr;
    bus.PWRITE    = wr;
    bus.PENABLE   = 1'b0;
    bus.PWDATA    = wdata;
    bus.PSTRB     = strb;
    wait_cfg[s*4 +: 4] = wt_v[3:0];
    @(negedge clock);
    check("ready_in_setup", {31'b0, bus.PREADY[s]}, 32'd0);
    @(posedge clock); #1;
    wait_cfg    = $urandom;
    bus.PENABLE = 1'b1;
    exp    = exp_q.pop_front();
    exp_wt = wait_q.pop_front();
    cyc    = 2;
    done   = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clock);
      if (bus.PREADY[s]) begin
        done = 1'b1;
        check("wait_states", cyc - 2, exp_wt);
        check("xfer_cycles", cyc, exp_wt + 2);
        check("pslverr", {31'b0, bus.PSLVERR[s]}, {31'b0, exp[32]});
        if (!wr) check("prdata", bus.PRDATA[s*32 +: 32], exp[31:0]);
      end else begin
        cyc++;
      end
      @(posedge clock); #1;
    end
    if (!done) check("ready_timeout", 32'd0, 32'd1);
    bus.PSELx   = '0;
    bus.PENABLE = 1'b0;
  endtask

  // scoreboard push + drive + model update
  task automatic xfer(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int wt, input bit use_given, input logic [32:0] given);
    bit          err;
    int          idx;
    logic [31:0] rd;
    err = (addr[1:0] != 2'b00) || (addr >= 32'h40);
    idx = int'(addr[5:2]);
    rd  = (err || wr) ? 32'd0 : model[s][idx];
    exp_q.push_back(use_given ? given : {err, rd});
    wait_q.push_back(eff_wait(wt));
    drive_xfer(s, wr, addr, wdata, strb, wt);
    if (wr && !err)
      for (int k = 0; k < 4; k++)
        if (strb[k]) model[s][idx][k*8 +: 8] = wdata[k*8 +: 8];
  endtask

  initial begin
    int abort_at;
    tbl[0]  = '{2, 1, 32'h8,        32'hDEADBEEF, 4'hF, 0, 32'h0,        0};
    tbl[1]  = '{2, 0, 32'h8,        32'h0,        4'h0, 0, 32'hDEADBEEF, 0};
    tbl[2]  = '{5, 0, 32'h0,        32'h0,        4'h0, 3, 32'h0,        0};
    tbl[3]  = '{3, 1, 32'h4,        32'hFFFFFFFF, 4'hF, 0, 32'h0,        0};
    tbl[4]  = '{3, 1, 32'h4,        32'h00000000, 4'h5, 1, 32'h0,        0};
    tbl[5]  = '{3, 0, 32'h4,        32'h0,        4'h0, 2, 32'hFF00FF00, 0};
    tbl[6]  = '{3, 1, 32'h4,        32'h12345678, 4'h0, 0, 32'h0,        0};
    tbl[7]  = '{3, 0, 32'h4,        32'h0,        4'h0, 0, 32'hFF00FF00, 0};
    tbl[8]  = '{4, 1, 32'h40,       32'h11111111, 4'hF, 0, 32'h0,        1};
    tbl[9]  = '{4, 0, 32'h40,       32'h0,        4'h0, 1, 32'h0,        1};
    tbl[10] = '{4, 1, 32'h2,        32'h22222222, 4'hF, 2, 32'h0,        1};
    tbl[11] = '{4, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0};
    tbl[12] = '{4, 0, 32'h2,        32'h0,        4'h0, 0, 32'h0,        1};
    tbl[13] = '{0, 1, 32'h3C,       32'hAAAA5555, 4'hF, 2, 32'h0,        0};
    tbl[14] = '{0, 0, 32'h3C,       32'h0,        4'h0, 0, 32'hAAAA5555, 0};
    tbl[15] = '{7, 1, 32'h3C,       32'h0F0F0F0F, 4'h3, 0, 32'h0,        0};
    tbl[16] = '{7, 0, 32'h3C,       32'h0,        4'h0, 1, 32'h00000F0F, 0};
    tbl[17] = '{2, 0, 32'h80000000, 32'h0,        4'h0, 0, 32'h0,        1};
    tbl[18] = '{0, 0, 32'h8,        32'h0,        4'h0, 0, 32'h0,        0};
    tbl[19] = '{2, 0, 32'h8,        32'h0,        4'h0, 0, 32'hDEADBEEF, 0};

    reset       = 1'b1;
    wait_cfg    = '0;
    bus.PSELx   = '0;
    bus.PADDR   = '0;
    bus.PWRITE  = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWDATA  = '0;
    bus.PSTRB   = '0;
    clear_model();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_pready",  {24'b0, bus.PREADY},  32'd0);
    check("rst_pslverr", {24'b0, bus.PSLVERR}, 32'd0);
    check("rst_prdata",  {31'b0, |bus.PRDATA}, 32'd0);
    check("rst_state",   {24'b0, state_dbg},   32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 20; i++)
      xfer(tbl[i].s, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].wt,
           1'b1, {tbl[i].err, tbl[i].rd});

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 17), 2'b00};
      if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
      xfer($urandom_range(0, 7), 1'($urandom_range(0, 1)), a, $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, 5), 1'b0, 33'd0);
    end

    // abort: PSEL dropped inside ACCESS; the write must not land
    abort_at = (eff_wait(4) >= 2) ? 2 : 1;
    bus.PSELx   = 8'b0000_0010;
    bus.PADDR   = 32'h10;
    bus.PWRITE  = 1'b1;
    bus.PWDATA  = 32'hCAFEF00D;
    bus.PSTRB   = 4'hF;
    bus.PENABLE = 1'b0;
    wait_cfg[4 +: 4] = 4'd4;
    @(posedge clock); #1;
    bus.PENABLE = 1'b1;
    repeat (abort_at - 1) begin
      @(posedge clock); #1;
    end
    bus.PSELx = '0;
    @(posedge clock); #1;
    bus.PENABLE = 1'b0;
    @(negedge clock);
    check("abort_pready", {31'b0, bus.PREADY[1]}, 32'd0);
    check("abort_state",  {31'b0, state_dbg[1]},  32'd0);
    @(posedge clock); #1;
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1, {1'b0, 32'h0});

    // reset in the middle of a write: outputs clear at once, write discarded
    bus.PSELx   = 8'b0000_0010;
    bus.PADDR   = 32'h10;
    bus.PWRITE  = 1'b1;
    bus.PWDATA  = 32'hCAFEF00D;
    bus.PSTRB   = 4'hF;
    bus.PENABLE = 1'b0;
    wait_cfg[4 +: 4] = 4'd4;
    @(posedge clock); #1;
    bus.PENABLE = 1'b1;
    repeat (abort_at - 1) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    #1;
    check("midrst_pready",  {24'b0, bus.PREADY},  32'd0);
    check("midrst_pslverr", {24'b0, bus.PSLVERR}, 32'd0);
    check("midrst_prdata",  {31'b0, |bus.PRDATA}, 32'd0);
    check("midrst_state",   {24'b0, state_dbg},   32'd0);
    bus.PSELx   = '0;
    bus.PENABLE = 1'b0;
    clear_model();
    @(posedge clock); #1;
    reset = 1'b0;
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1, {1'b0, 32'h0});
    xfer(2, 1'b0, 32'h8,  32'h0, 4'h0, 0, 1'b1, {1'b0, 32'h0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
